ifc_combine_pipe: RTL and testbench
===================================

IFC_COMBINE_PIPE -- requirements
Module: ifc_combine_pipe

Interface
- REQ-001 Parameter NA, default 8: width of operands A and B.
- REQ-002 Parameter NX, default 16: width of the interface fields X, Y, Z and of each accumulator; NX >= NA SHALL be enforced at elaboration.
- REQ-003 Parameter NCH, default 4: number of channels; channel index width CW = max(1, clog2(NCH)).
- REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
- REQ-005 CLK  in  1  clock; all state changes on the rising edge.
- REQ-006 RST  in  1  synchronous active-high reset.
- REQ-007 IN_VALID  in  1  input transfer request.
- REQ-008 IN_READY  out  1  input transfer accepted when high together with IN_VALID.
- REQ-009 IN_CH  in  CW  channel index of the transfer.
- REQ-010 IN_MODE  in  1  0 = combine, 1 = accumulate.
- REQ-011 IN_CLR  in  1  accumulate mode only: clear the channel accumulator before adding.
- REQ-012 A, B  in  NA each  logic operands.
- REQ-013 IFC_X, IFC_Y  in  NX each  interface addends.
- REQ-014 OUT_VALID  out  1  result available.
- REQ-015 OUT_READY  in  1  consumer accepts the result.
- REQ-016 OUT_CH  out  CW  channel index of the result.
- REQ-017 IFC_Z  out  NX  result.

Function
- REQ-018 Per transfer: L = zero-extend(A | B) to NX bits; S = IFC_X + IFC_Y truncated to NX bits (wrapping); R = L | S.
- REQ-019 Mode 0: IFC_Z = R; accumulators unchanged.
- REQ-020 Mode 1: ACC[IN_CH] <= (IN_CLR ? 0 : ACC[IN_CH]) + R, wrapping at NX bits; IFC_Z = the new ACC value.
- REQ-021 Two-stage pipeline: stage 1 registers L, S, channel, mode and clear; stage 2 registers R or the accumulated value into IFC_Z.
- REQ-022 Pipeline enable EN = !OUT_VALID || OUT_READY; IN_READY = EN (combinational); when EN = 0, every stage holds.
- REQ-023 Latency: a transfer accepted in cycle n appears with OUT_VALID = 1 in cycle n+2 if EN stayed high; throughput is one transfer per cycle.
- REQ-024 IFC_Z, OUT_CH and OUT_VALID SHALL stay stable while OUT_VALID = 1 and OUT_READY = 0.
- REQ-025 The accumulator is read and written in stage 2 only; back-to-back accumulate transfers on the same channel SHALL each see the previous update (no hazard, no bubble).
- REQ-026 Stage bubbles (no input accepted) propagate as OUT_VALID = 0; they do not change the accumulators.
- REQ-027 IN_CH >= NCH: the transfer is accepted and the result is output; in mode 1 no accumulator is written and IFC_Z = R.
- REQ-028 IN_CLR is ignored in mode 0.

Reset
- REQ-029 While RST = 1: OUT_VALID = 0, IFC_Z = 0, OUT_CH = 0, all stage-valid flags = 0, all ACC = 0; IN_READY = 1.
- REQ-030 A reset asserted mid-stream discards all in-flight transfers; no partial result is ever presented.
- REQ-031 The first transfer can be accepted in the first cycle after RST deasserts.

Configuration
- REQ-032 Macro IFC_COMBINE_SAT_EN defined: S and the mode-1 accumulation saturate at 2^NX - 1 instead of wrapping.
- REQ-033 Macro IFC_COMBINE_SAT_EN absent: all additions wrap modulo 2^NX; no saturation logic is present.

Verification (NA=8, NX=16, NCH=4)
- REQ-034 Mode 0, A=0x0C, B=0x03, X=17, Y=21, OUT_READY=1 -> two cycles later OUT_VALID=1, IFC_Z=0x002F.
- REQ-035 Mode 1, channel 2, three back-to-back transfers with R = 5 each, first with IN_CLR=1 -> IFC_Z = 5, 10, 15 on consecutive cycles; the accumulators of channels 0, 1 and 3 stay 0.
- REQ-036 OUT_READY held low for 4 cycles with a valid result -> IN_READY=0 and IFC_Z stable; after release the results drain in order with none lost or duplicated.
- REQ-037 X=0xFFFF, Y=0x0002, A=B=0 -> IFC_Z=0x0001 without the macro; 0xFFFF with IFC_COMBINE_SAT_EN.
- REQ-038 RST pulsed with two transfers in flight -> OUT_VALID=0 next cycle, the accumulators read 0 on subsequent mode-1 transfers.
- REQ-039 Mode 1 with IN_CH=5 (out of range) -> IFC_Z=R and OUT_CH=5 mod 4 truncation is not applied; the accumulators are unchanged.

Source files
------------

// File: rtl/ifc_combine_pipe_if.sv
// Handshake and data bundle for ifc_combine_pipe: input transfer, result and flow control.
// master = producer/consumer side (testbench or upstream), slave = the pipeline itself.
interface ifc_combine_pipe_if #(
  parameter int NA  = 8,
  parameter int NX  = 16,
  parameter int NCH = 4
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ch;
  logic          in_mode;
  logic          in_clr;
  logic [NA-1:0] a;
  logic [NA-1:0] b;
  logic [NX-1:0] ifc_x;
  logic [NX-1:0] ifc_y;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ch;
  logic [NX-1:0] ifc_z;

  modport master (
    output in_valid, in_ch, in_mode, in_clr, a, b, ifc_x, ifc_y, out_ready,
    input  in_ready, out_valid, out_ch, ifc_z
  );

  modport slave (
    input  in_valid, in_ch, in_mode, in_clr, a, b, ifc_x, ifc_y, out_ready,
    output in_ready, out_valid, out_ch, ifc_z
  );
endinterface

// File: rtl/ifc_combine_pipe.sv
// Two-stage combine/accumulate pipeline: Z = (A|B) | (X+Y), optionally summed into a per-channel accumulator.
// Define IFC_COMBINE_SAT_EN to make the X+Y sum and the accumulation saturate instead of wrapping.
module ifc_combine_pipe #(
  parameter int NA  = 8,
  parameter int NX  = 16,
  parameter int NCH = 4
) (
  input logic clk,
  input logic rst,
  ifc_combine_pipe_if.slave bus
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  if (NX < NA) begin : g_width_check
    $error("ifc_combine_pipe: NX must be >= NA");
  end

  logic          en;
  logic          v1;
  logic          mode1;
  logic          clr1;
  logic [CW-1:0] ch1;
  logic [NX-1:0] l1;
  logic [NX-1:0] s1;
  logic [NX-1:0] s_next;

  logic          out_valid_q;
  logic [CW-1:0] out_ch_q;
  logic [NX-1:0] z_q;
  logic [NX-1:0] acc [NCH];

  logic [NX-1:0] r2;
  logic [NX-1:0] acc_cur;
  logic [NX-1:0] acc_base;
  logic [NX-1:0] acc_sum;
  logic          acc_hit;
  logic          acc_wr;

  assign en           = !out_valid_q || bus.out_ready;
  assign bus.in_ready = rst || en;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.ifc_z     = z_q;

`ifdef IFC_COMBINE_SAT_EN
  logic [NX:0] s_full;
  assign s_full = {1'b0, bus.ifc_x} + {1'b0, bus.ifc_y};
  assign s_next = s_full[NX] ? '1 : s_full[NX-1:0];
`else
  assign s_next = bus.ifc_x + bus.ifc_y;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      mode1 <= 1'b0;
      clr1  <= 1'b0;
      ch1   <= '0;
      l1    <= '0;
      s1    <= '0;
    end else if (en) begin
      v1    <= bus.in_valid;
      mode1 <= bus.in_mode;
      clr1  <= bus.in_clr;
      ch1   <= bus.in_ch;
      l1    <= NX'(bus.a | bus.b);
      s1    <= s_next;
    end
  end

  // Channel lookup by comparison so out-of-range indices simply miss instead of indexing past the array.
  always_comb begin
    acc_hit = 1'b0;
    acc_cur = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch1 == CW'(i)) begin
        acc_hit = 1'b1;
        acc_cur = acc[i];
      end
    end
  end

  assign r2       = l1 | s1;
  assign acc_base = clr1 ? '0 : acc_cur;
  assign acc_wr   = v1 && mode1 && acc_hit;

`ifdef IFC_COMBINE_SAT_EN
  logic [NX:0] acc_full;
  assign acc_full = {1'b0, acc_base} + {1'b0, r2};
  assign acc_sum  = acc_full[NX] ? '1 : acc_full[NX-1:0];
`else
  assign acc_sum = acc_base + r2;
`endif

  // Accumulators live entirely in stage 2, so consecutive same-channel updates chain without a hazard.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      z_q         <= '0;
      for (int i = 0; i < NCH; i++) begin
        acc[i] <= '0;
      end
    end else if (en) begin
      out_valid_q <= v1;
      if (v1) begin
        out_ch_q <= ch1;
        z_q      <= acc_wr ? acc_sum : r2;
      end
      for (int i = 0; i < NCH; i++) begin
        if (acc_wr && ch1 == CW'(i)) begin
          acc[i] <= acc_sum;
        end
      end
    end
  end
endmodule

// File: tb/tb_ifc_combine_pipe.sv
// Directed bench for ifc_combine_pipe: a 4-channel instance for the main behaviour and a
// 5-channel instance so that channel indices beyond NCH are representable.
module tb_ifc_combine_pipe;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  ifc_combine_pipe_if #(.NA(8), .NX(16), .NCH(4)) bus ();
  ifc_combine_pipe_if #(.NA(8), .NX(16), .NCH(5)) bus2 ();

  ifc_combine_pipe #(.NA(8), .NX(16), .NCH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  ifc_combine_pipe #(.NA(8), .NX(16), .NCH(5)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input int v, input int ch, input int mode, input int clr,
                       input int a, input int b, input int x, input int y);
    bus.in_valid = 1'(v);
    bus.in_ch    = 2'(ch);
    bus.in_mode  = 1'(mode);
    bus.in_clr   = 1'(clr);
    bus.a        = 8'(a);
    bus.b        = 8'(b);
    bus.ifc_x    = 16'(x);
    bus.ifc_y    = 16'(y);
  endtask

  task automatic drive2(input int v, input int ch, input int mode, input int clr, input int a);
    bus2.in_valid = 1'(v);
    bus2.in_ch    = 3'(ch);
    bus2.in_mode  = 1'(mode);
    bus2.in_clr   = 1'(clr);
    bus2.a        = 8'(a);
    bus2.b        = 8'h00;
    bus2.ifc_x    = 16'h0000;
    bus2.ifc_y    = 16'h0000;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.out_ready  = 1'b0;
    bus2.out_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive2(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    vectors++;
    if (bus.ifc_z !== 16'h0000) begin
      miscompares++; $display("[TB] FAIL reset_z: got %h want 0000", bus.ifc_z);
    end
    vectors++;
    if (bus.out_ch !== 2'd0) begin
      miscompares++; $display("[TB] FAIL reset_out_ch: got %0d want 0", bus.out_ch);
    end
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++; $display("[TB] FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    vectors++;
    if (bus2.out_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_out_valid2: got %b want 0", bus2.out_valid);
    end
  endtask

  task automatic test_combine();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    drive(1, 1, 0, 0, 8'h0C, 8'h03, 17, 21);
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL comb_latency: got valid %b want 0", bus.out_valid);
    end
    drive(1, 3, 0, 0, 8'hF0, 8'h00, 16'h1000, 16'h0234);
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.ifc_z !== 16'h002F || bus.out_ch !== 2'd1) begin
      miscompares++;
      $display("[TB] FAIL comb_first: got v=%b z=%h ch=%0d want v=1 z=002f ch=1",
               bus.out_valid, bus.ifc_z, bus.out_ch);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.ifc_z !== 16'h12F4 || bus.out_ch !== 2'd3) begin
      miscompares++;
      $display("[TB] FAIL comb_second: got v=%b z=%h ch=%0d want v=1 z=12f4 ch=3",
               bus.out_valid, bus.ifc_z, bus.out_ch);
    end
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL comb_bubble: got valid %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_accumulate();
    int ch_t[8]   = '{2, 2, 2, 0, 1, 3, 2, 2};
    int mode_t[8] = '{1, 1, 1, 1, 1, 1, 0, 1};
    int clr_t[8]  = '{1, 0, 0, 0, 0, 0, 1, 0};
    int a_t[8]    = '{5, 5, 5, 0, 0, 0, 7, 0};
    int exp_t[8]  = '{5, 10, 15, 0, 0, 0, 7, 15};
    for (int i = 0; i < 10; i++) begin
      if (i >= 2) begin
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.ifc_z !== 16'(exp_t[i-2]) || bus.out_ch !== 2'(ch_t[i-2])) begin
          miscompares++;
          $display("[TB] FAIL acc_step%0d: got v=%b z=%0d ch=%0d want v=1 z=%0d ch=%0d",
                   i - 2, bus.out_valid, bus.ifc_z, bus.out_ch, exp_t[i-2], ch_t[i-2]);
        end
      end
      if (i < 8) drive(1, ch_t[i], mode_t[i], clr_t[i], a_t[i], 0, 0, 0);
      else       drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back_stall();
    drive(1, 0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    drive(1, 2, 0, 0, 2, 0, 0, 0);
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.ifc_z !== 16'd1) begin
      miscompares++; $display("[TB] FAIL stall_first: got v=%b z=%0d want v=1 z=1", bus.out_valid, bus.ifc_z);
    end
    bus.out_ready = 1'b0;
    drive(1, 1, 0, 0, 3, 0, 0, 0);
    #1;
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++; $display("[TB] FAIL stall_in_ready: got %b want 0", bus.in_ready);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.ifc_z !== 16'd1 || bus.out_ch !== 2'd0 || bus.in_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL stall_hold%0d: got v=%b z=%0d ch=%0d rdy=%b want v=1 z=1 ch=0 rdy=0",
                 k, bus.out_valid, bus.ifc_z, bus.out_ch, bus.in_ready);
      end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.ifc_z !== 16'd2 || bus.out_ch !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL stall_drain2: got v=%b z=%0d ch=%0d want v=1 z=2 ch=2", bus.out_valid, bus.ifc_z, bus.out_ch);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.ifc_z !== 16'd3 || bus.out_ch !== 2'd1) begin
      miscompares++;
      $display("[TB] FAIL stall_drain3: got v=%b z=%0d ch=%0d want v=1 z=3 ch=1", bus.out_valid, bus.ifc_z, bus.out_ch);
    end
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL stall_empty: got valid %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_saturate();
    logic [15:0] exp_z;
`ifdef IFC_COMBINE_SAT_EN
    exp_z = 16'hFFFF;
`else
    exp_z = 16'h0001;
`endif
    drive(1, 0, 0, 0, 0, 0, 16'hFFFF, 16'h0002);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.ifc_z !== exp_z) begin
      miscompares++; $display("[TB] FAIL sum_overflow: got v=%b z=%h want v=1 z=%h", bus.out_valid, bus.ifc_z, exp_z);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midstream();
    drive(1, 2, 1, 0, 1, 0, 0, 0);
    @(negedge clk);
    drive(1, 2, 1, 0, 1, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL rst_flush1: got valid %b want 0", bus.out_valid);
    end
    rst = 1'b0;
    drive(1, 2, 1, 0, 3, 0, 0, 0);
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL rst_flush2: got valid %b want 0", bus.out_valid);
    end
    drive(1, 0, 1, 0, 4, 0, 0, 0);
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.ifc_z !== 16'd3) begin
      miscompares++; $display("[TB] FAIL rst_acc_ch2: got v=%b z=%0d want v=1 z=3", bus.out_valid, bus.ifc_z);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.ifc_z !== 16'd4) begin
      miscompares++; $display("[TB] FAIL rst_acc_ch0: got v=%b z=%0d want v=1 z=4", bus.out_valid, bus.ifc_z);
    end
    @(negedge clk);
  endtask

  task automatic test_out_of_range();
    int ch_t[5]  = '{4, 5, 5, 7, 4};
    int clr_t[5] = '{1, 0, 1, 0, 0};
    int a_t[5]   = '{9, 6, 2, 1, 0};
    int exp_t[5] = '{9, 6, 2, 1, 9};
    for (int i = 0; i < 7; i++) begin
      if (i >= 2) begin
        vectors++;
        if (bus2.out_valid !== 1'b1 || bus2.ifc_z !== 16'(exp_t[i-2]) || bus2.out_ch !== 3'(ch_t[i-2])) begin
          miscompares++;
          $display("[TB] FAIL range_step%0d: got v=%b z=%0d ch=%0d want v=1 z=%0d ch=%0d",
                   i - 2, bus2.out_valid, bus2.ifc_z, bus2.out_ch, exp_t[i-2], ch_t[i-2]);
        end
      end
      if (i < 5) drive2(1, ch_t[i], 1, clr_t[i], a_t[i]);
      else       drive2(0, 0, 0, 0, 0);
      @(negedge clk);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_combine();
    test_accumulate();
    test_back_to_back_stall();
    test_saturate();
    test_reset_midstream();
    test_out_of_range();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
